// File: rtl/gray_overlay_pkg.sv
// Shared constants and types for the gray/threshold marker overlay stage.
package gray_overlay_pkg;

  localparam logic [1:0] MODE_COLOR  = 2'd0;
  localparam logic [1:0] MODE_GRAY   = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd2;

  // BT.601-style integer luma weights; their sum is 256, so full white stays full white
  localparam int LUMA_R     = 32'd77;
  localparam int LUMA_G     = 32'd150;
  localparam int LUMA_B     = 32'd29;
  localparam int LUMA_SHIFT = 32'd8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } load_state_e;

endpackage

// File: rtl/gray_marker_overlay_if.sv
// Pixel-stream and marker-configuration bundle between the tracker/demosaic side and the overlay stage.
interface gray_marker_overlay_if #(
  parameter int DATA_W      = 10,
  parameter int COORD_W     = 13,
  parameter int NUM_MARKERS = 2
);

  logic                           iDVAL;
  logic [DATA_W-1:0]              iRed;
  logic [DATA_W-1:0]              iGreen;
  logic [DATA_W-1:0]              iBlue;
  logic [COORD_W-1:0]             iH_Cont;
  logic [COORD_W-1:0]             iV_Cont;
  logic [1:0]                     iMode;
  logic [DATA_W-1:0]              iThresh;
  logic [NUM_MARKERS*COORD_W-1:0] iPos_X;
  logic [NUM_MARKERS*COORD_W-1:0] iPos_Y;
  logic [NUM_MARKERS-1:0]         iMark_En;
  logic                           iLoad;
  logic                           oDVAL;
  logic [DATA_W-1:0]              oDATA_R;
  logic [DATA_W-1:0]              oDATA_G;
  logic [DATA_W-1:0]              oDATA_B;
  logic                           oPending;

  modport master (
    output iDVAL, iRed, iGreen, iBlue, iH_Cont, iV_Cont, iMode, iThresh,
           iPos_X, iPos_Y, iMark_En, iLoad,
    input  oDVAL, oDATA_R, oDATA_G, oDATA_B, oPending
  );

  modport slave (
    input  iDVAL, iRed, iGreen, iBlue, iH_Cont, iV_Cont, iMode, iThresh,
           iPos_X, iPos_Y, iMark_En, iLoad,
    output oDVAL, oDATA_R, oDATA_G, oDATA_B, oPending
  );

endinterface

// File: rtl/marker_hit.sv
// Per-marker box test: filled square by default, 2-pixel outline when GRAY_MARKER_OUTLINE_EN is defined.
module marker_hit #(
  parameter int COORD_W  = 13,
  parameter int BOX_SIZE = 40
) (
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_h,
  input  logic [COORD_W-1:0] i_v,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_inside
);

  localparam logic [COORD_W:0] BOX_W = (COORD_W+1)'(BOX_SIZE);

  logic [COORD_W:0] w_h;
  logic [COORD_W:0] w_v;
  logic [COORD_W:0] w_x;
  logic [COORD_W:0] w_y;
  logic             w_in_box;

  // One guard bit keeps X+BOX_SIZE from wrapping near the top of the coordinate range
  assign w_h = {1'b0, i_h};
  assign w_v = {1'b0, i_v};
  assign w_x = {1'b0, i_x};
  assign w_y = {1'b0, i_y};

  assign w_in_box = i_en && (w_h > w_x) && (w_h < w_x + BOX_W)
                         && (w_v > w_y) && (w_v < w_y + BOX_W);

`ifdef GRAY_MARKER_OUTLINE_EN
  localparam logic [COORD_W:0] EDGE_W = (COORD_W+1)'(32'd3);

  logic w_interior;

  assign w_interior = (w_h >= w_x + EDGE_W) && (w_h <= w_x + BOX_W - EDGE_W)
                   && (w_v >= w_y + EDGE_W) && (w_v <= w_y + BOX_W - EDGE_W);
  assign o_inside   = w_in_box && !w_interior;
`else
  assign o_inside   = w_in_box;
`endif

endmodule

// File: rtl/gray_marker_overlay.sv
// Colour/gray/threshold conversion with frame-synchronous marker overlay; 3-cycle fixed latency.
// Optional outline-only markers: define GRAY_MARKER_OUTLINE_EN.
module gray_marker_overlay
  import gray_overlay_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int COORD_W     = 13,
  parameter int NUM_MARKERS = 2,
  parameter int BOX_SIZE    = 40
) (
  input logic                  iCLK,
  input logic                  iRST,
  gray_marker_overlay_if.slave bus
);

  localparam int PROD_W = DATA_W + 8;
  localparam int POS_W  = NUM_MARKERS * COORD_W;

  load_state_e r_state;
  load_state_e w_state_next;
  logic        w_frame_start;
  logic        w_use_in;
  logic        w_use_stg;
  logic        r_pending;

  logic [POS_W-1:0]       r_stg_x, r_stg_y, r_act_x, r_act_y, w_eff_x, w_eff_y;
  logic [NUM_MARKERS-1:0] r_stg_en, r_act_en, w_eff_en, w_inside;
  logic [1:0]             r_stg_mode, r_act_mode, w_eff_mode;
  logic [DATA_W-1:0]      r_stg_thresh, r_act_thresh, w_eff_thresh;

  logic [PROD_W-1:0]      w_prod_r, w_prod_g, w_prod_b;
  logic                   r_s1_dval;
  logic [DATA_W-1:0]      r_s1_r, r_s1_g, r_s1_b, r_s1_thresh;
  logic [PROD_W-1:0]      r_s1_prod_r, r_s1_prod_g, r_s1_prod_b;
  logic [NUM_MARKERS-1:0] r_s1_inside;
  logic [1:0]             r_s1_mode;

  logic [PROD_W-1:0]      w_sum;
  logic [DATA_W-1:0]      w_gray, w_bin;
  logic                   r_s2_dval, r_s2_inside;
  logic [DATA_W-1:0]      r_s2_r, r_s2_g, r_s2_b, r_s2_gray, r_s2_bin;
  logic [1:0]             r_s2_mode;

  logic [DATA_W-1:0]      w_out_r, w_out_g, w_out_b;
  logic                   r_o_dval;
  logic [DATA_W-1:0]      r_o_r, r_o_g, r_o_b;

  assign w_frame_start = bus.iDVAL && (bus.iH_Cont == {COORD_W{1'b0}})
                                   && (bus.iV_Cont == {COORD_W{1'b0}});

  // Load FSM state register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Load FSM next state and selection of the configuration seen by the current pixel
  always_comb begin
    w_state_next = r_state;
    w_use_in     = 1'b0;
    w_use_stg    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.iLoad && w_frame_start) begin
          w_use_in = 1'b1;
        end else if (bus.iLoad) begin
          w_state_next = ST_PENDING;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (w_frame_start) begin
          w_use_in     = bus.iLoad;
          w_use_stg    = !bus.iLoad;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_PENDING;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_eff_x      = w_use_in ? bus.iPos_X   : (w_use_stg ? r_stg_x      : r_act_x);
  assign w_eff_y      = w_use_in ? bus.iPos_Y   : (w_use_stg ? r_stg_y      : r_act_y);
  assign w_eff_en     = w_use_in ? bus.iMark_En : (w_use_stg ? r_stg_en     : r_act_en);
  assign w_eff_mode   = w_use_in ? bus.iMode    : (w_use_stg ? r_stg_mode   : r_act_mode);
  assign w_eff_thresh = w_use_in ? bus.iThresh  : (w_use_stg ? r_stg_thresh : r_act_thresh);

  // Staging and active configuration; active simply follows the effective selection
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_pending    <= 1'b0;
      r_stg_x      <= {POS_W{1'b0}};
      r_stg_y      <= {POS_W{1'b0}};
      r_stg_en     <= {NUM_MARKERS{1'b0}};
      r_stg_mode   <= 2'd0;
      r_stg_thresh <= {DATA_W{1'b0}};
      r_act_x      <= {POS_W{1'b0}};
      r_act_y      <= {POS_W{1'b0}};
      r_act_en     <= {NUM_MARKERS{1'b0}};
      r_act_mode   <= 2'd0;
      r_act_thresh <= {DATA_W{1'b0}};
    end else begin
      r_pending    <= (w_state_next == ST_PENDING);
      if (bus.iLoad) begin
        r_stg_x      <= bus.iPos_X;
        r_stg_y      <= bus.iPos_Y;
        r_stg_en     <= bus.iMark_En;
        r_stg_mode   <= bus.iMode;
        r_stg_thresh <= bus.iThresh;
      end
      r_act_x      <= w_eff_x;
      r_act_y      <= w_eff_y;
      r_act_en     <= w_eff_en;
      r_act_mode   <= w_eff_mode;
      r_act_thresh <= w_eff_thresh;
    end
  end

  for (genvar k = 0; k < NUM_MARKERS; k++) begin : g_hit
    marker_hit #(
      .COORD_W  (COORD_W),
      .BOX_SIZE (BOX_SIZE)
    ) u_hit (
      .i_en     (w_eff_en[k]),
      .i_h      (bus.iH_Cont),
      .i_v      (bus.iV_Cont),
      .i_x      (w_eff_x[k*COORD_W +: COORD_W]),
      .i_y      (w_eff_y[k*COORD_W +: COORD_W]),
      .o_inside (w_inside[k])
    );
  end

  assign w_prod_r = PROD_W'(bus.iRed)   * PROD_W'(LUMA_R);
  assign w_prod_g = PROD_W'(bus.iGreen) * PROD_W'(LUMA_G);
  assign w_prod_b = PROD_W'(bus.iBlue)  * PROD_W'(LUMA_B);

  assign w_sum  = r_s1_prod_r + r_s1_prod_g + r_s1_prod_b;
  assign w_gray = DATA_W'(w_sum >> LUMA_SHIFT);
  assign w_bin  = (w_gray >= r_s1_thresh) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

  // Output mux; markers win over the processed image
  always_comb begin
    w_out_r = {DATA_W{1'b0}};
    w_out_g = {DATA_W{1'b0}};
    w_out_b = {DATA_W{1'b0}};
    if (r_s2_dval) begin
      case (r_s2_mode)
        MODE_COLOR: begin
          if (r_s2_inside) begin
            w_out_r = {DATA_W{1'b1}};
          end else begin
            w_out_r = r_s2_r;
            w_out_g = r_s2_g;
            w_out_b = r_s2_b;
          end
        end
        MODE_THRESH: begin
          if (!r_s2_inside) begin
            w_out_r = r_s2_bin;
            w_out_g = r_s2_bin;
            w_out_b = r_s2_bin;
          end else begin
            w_out_r = {DATA_W{1'b0}};
          end
        end
        MODE_GRAY: begin
          if (!r_s2_inside) begin
            w_out_r = r_s2_gray;
            w_out_g = r_s2_gray;
            w_out_b = r_s2_gray;
          end else begin
            w_out_r = {DATA_W{1'b0}};
          end
        end
        default: begin
          if (!r_s2_inside) begin
            w_out_r = r_s2_gray;
            w_out_g = r_s2_gray;
            w_out_b = r_s2_gray;
          end else begin
            w_out_r = {DATA_W{1'b0}};
          end
        end
      endcase
    end else begin
      w_out_r = {DATA_W{1'b0}};
    end
  end

  // Three pipeline stages; mode and threshold travel with each pixel
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_s1_dval   <= 1'b0;
      r_s1_r      <= {DATA_W{1'b0}};
      r_s1_g      <= {DATA_W{1'b0}};
      r_s1_b      <= {DATA_W{1'b0}};
      r_s1_prod_r <= {PROD_W{1'b0}};
      r_s1_prod_g <= {PROD_W{1'b0}};
      r_s1_prod_b <= {PROD_W{1'b0}};
      r_s1_inside <= {NUM_MARKERS{1'b0}};
      r_s1_mode   <= 2'd0;
      r_s1_thresh <= {DATA_W{1'b0}};
      r_s2_dval   <= 1'b0;
      r_s2_r      <= {DATA_W{1'b0}};
      r_s2_g      <= {DATA_W{1'b0}};
      r_s2_b      <= {DATA_W{1'b0}};
      r_s2_gray   <= {DATA_W{1'b0}};
      r_s2_bin    <= {DATA_W{1'b0}};
      r_s2_inside <= 1'b0;
      r_s2_mode   <= 2'd0;
      r_o_dval    <= 1'b0;
      r_o_r       <= {DATA_W{1'b0}};
      r_o_g       <= {DATA_W{1'b0}};
      r_o_b       <= {DATA_W{1'b0}};
    end else begin
      r_s1_dval   <= bus.iDVAL;
      r_s1_r      <= bus.iRed;
      r_s1_g      <= bus.iGreen;
      r_s1_b      <= bus.iBlue;
      r_s1_prod_r <= w_prod_r;
      r_s1_prod_g <= w_prod_g;
      r_s1_prod_b <= w_prod_b;
      r_s1_inside <= w_inside;
      r_s1_mode   <= w_eff_mode;
      r_s1_thresh <= w_eff_thresh;
      r_s2_dval   <= r_s1_dval;
      r_s2_r      <= r_s1_r;
      r_s2_g      <= r_s1_g;
      r_s2_b      <= r_s1_b;
      r_s2_gray   <= w_gray;
      r_s2_bin    <= w_bin;
      r_s2_inside <= |r_s1_inside;
      r_s2_mode   <= r_s1_mode;
      r_o_dval    <= r_s2_dval;
      r_o_r       <= w_out_r;
      r_o_g       <= w_out_g;
      r_o_b       <= w_out_b;
    end
  end

  assign bus.oDVAL    = r_o_dval;
  assign bus.oDATA_R  = r_o_r;
  assign bus.oDATA_G  = r_o_g;
  assign bus.oDATA_B  = r_o_b;
  assign bus.oPending = r_pending;

endmodule
